// File: rtl/unipolar_rz_pkg.sv
// Shared types and helpers for the unipolar return-to-zero (WS2812-style) line codec.
package unipolar_rz_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HIGH   = 2'd1,
    LOW    = 2'd2,
    RESYNC = 2'd3
  } state_t;

  // Converts a duration in seconds to a whole number of clock cycles (rounded).
  function automatic int time_to_count(real clock_rate, real t);
    return int'(clock_rate * t);
  endfunction

endpackage

// File: rtl/unipolar_rz_sync.sv
// Two-flop synchronizer for an asynchronous single-wire input, plus rise/fall pulses
// taken from the synchronized level against one extra history register.
module unipolar_rz_sync (
  input  logic clock,
  input  logic reset,
  input  logic i_line,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic r_meta;
  logic r_sync;
  logic r_prev;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
      r_prev <= 1'b0;
    end else begin
      r_meta <= i_line;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign o_level = r_sync;
  assign o_rise  = r_sync & ~r_prev;
  assign o_fall  = ~r_sync & r_prev;

endmodule

// File: rtl/unipolar_rz_decoder.sv
// Unipolar RZ receiver: classifies each high pulse by width, assembles MSB-first words,
// and flags the long-low latch gap. Define UNIPOLAR_RZ_DECODER_FORWARD_EN for chain forwarding.
module unipolar_rz_decoder #(
  parameter int  DATA_WIDTH     = 24,
  parameter real CLOCK_RATE     = 100e6,
  parameter real PERIOD_TIME    = 1.2e-6,
  parameter real ZERO_HIGH_TIME = 0.3e-6,
  parameter real ONE_HIGH_TIME  = 0.8e-6,
  parameter real RESET_TIME     = 90e-6
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  line,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  valid,
  output logic                  frame_end,
  output logic                  error,
  output logic                  line_out
);
  import unipolar_rz_pkg::*;

  localparam int PERIOD_COUNT    = time_to_count(CLOCK_RATE, PERIOD_TIME);
  localparam int ZERO_HIGH_COUNT = time_to_count(CLOCK_RATE, ZERO_HIGH_TIME);
  localparam int ONE_HIGH_COUNT  = time_to_count(CLOCK_RATE, ONE_HIGH_TIME);
  localparam int THRESHOLD       = (ZERO_HIGH_COUNT + ONE_HIGH_COUNT) / 2;
  localparam int RESET_COUNT     = time_to_count(CLOCK_RATE, RESET_TIME);
  localparam int CNT_W           = $clog2(RESET_COUNT + 1);
  localparam int IDX_W           = $clog2(DATA_WIDTH + 1);

  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_PERIOD = CNT_W'(PERIOD_COUNT);
  localparam logic [CNT_W-1:0] CNT_THRESH = CNT_W'(THRESHOLD);
  localparam logic [CNT_W-1:0] CNT_RESET  = CNT_W'(RESET_COUNT);
  localparam logic [IDX_W-1:0] IDX_FULL   = IDX_W'(DATA_WIDTH);

  logic w_level;
  logic w_rise;
  logic w_fall;

  unipolar_rz_sync u_sync (
    .clock   (clock),
    .reset   (reset),
    .i_line  (line),
    .o_level (w_level),
    .o_rise  (w_rise),
    .o_fall  (w_fall)
  );

  state_t                r_state;
  logic [CNT_W-1:0]      r_cnt;
  logic [DATA_WIDTH-1:0] r_shift;
  logic [IDX_W-1:0]      r_idx;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_valid;
  logic                  r_frame_end;
  logic                  r_error;

  state_t                w_state_nxt;
  logic [CNT_W-1:0]      w_cnt_nxt;
  logic [DATA_WIDTH-1:0] w_shift_nxt;
  logic [IDX_W-1:0]      w_idx_nxt;
  logic [DATA_WIDTH-1:0] w_data_nxt;
  logic                  w_valid_nxt;
  logic                  w_frame_end_nxt;
  logic                  w_error_nxt;
  logic [CNT_W-1:0]      w_cnt_inc;
  logic                  w_bit;

`ifdef UNIPOLAR_RZ_DECODER_FORWARD_EN
  logic r_fwd;
  logic w_fwd_nxt;
`endif

  // The counter saturates at the reset count so an arbitrarily long idle never wraps.
  assign w_cnt_inc = (r_cnt >= CNT_RESET) ? r_cnt : r_cnt + 1'b1;
  assign w_bit     = (r_cnt >= CNT_THRESH);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_shift     <= '0;
      r_idx       <= '0;
      r_data      <= '0;
      r_valid     <= 1'b0;
      r_frame_end <= 1'b0;
      r_error     <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_shift     <= w_shift_nxt;
      r_idx       <= w_idx_nxt;
      r_data      <= w_data_nxt;
      r_valid     <= w_valid_nxt;
      r_frame_end <= w_frame_end_nxt;
      r_error     <= w_error_nxt;
    end
  end

`ifdef UNIPOLAR_RZ_DECODER_FORWARD_EN
  always_ff @(posedge clock) begin
    if (reset) r_fwd <= 1'b0;
    else       r_fwd <= w_fwd_nxt;
  end
`endif

  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_shift_nxt     = r_shift;
    w_idx_nxt       = r_idx;
    w_data_nxt      = r_data;
    w_valid_nxt     = 1'b0;
    w_frame_end_nxt = 1'b0;
    w_error_nxt     = 1'b0;
`ifdef UNIPOLAR_RZ_DECODER_FORWARD_EN
    w_fwd_nxt       = r_fwd;
`endif

    // A full word is published one cycle after its last bit was shifted in; the FSM is
    // then in LOW (or just re-entering HIGH), so this never collides with a shift.
    if (r_idx == IDX_FULL) begin
      w_idx_nxt = '0;
`ifdef UNIPOLAR_RZ_DECODER_FORWARD_EN
      if (!r_fwd) begin
        w_data_nxt  = r_shift;
        w_valid_nxt = 1'b1;
      end
      w_fwd_nxt = 1'b1;
`else
      w_data_nxt  = r_shift;
      w_valid_nxt = 1'b1;
`endif
    end

    case (r_state)
      IDLE: begin
        if (w_rise) begin
          w_state_nxt = HIGH;
          w_cnt_nxt   = CNT_ONE;
        end
      end
      HIGH: begin
        if (r_cnt >= CNT_PERIOD) begin
          w_error_nxt = 1'b1;
          w_shift_nxt = '0;
          w_idx_nxt   = '0;
          w_cnt_nxt   = '0;
          w_state_nxt = RESYNC;
        end else if (w_fall) begin
          w_shift_nxt = {r_shift[DATA_WIDTH-2:0], w_bit};
          w_idx_nxt   = r_idx + 1'b1;
          w_cnt_nxt   = CNT_ONE;
          w_state_nxt = LOW;
        end else begin
          w_cnt_nxt = w_cnt_inc;
        end
      end
      LOW: begin
        if (w_rise) begin
          w_state_nxt = HIGH;
          w_cnt_nxt   = CNT_ONE;
        end else if (r_cnt >= CNT_RESET) begin
          w_frame_end_nxt = 1'b1;
          w_state_nxt     = IDLE;
          if (r_idx != '0) begin
            w_error_nxt = 1'b1;
            w_shift_nxt = '0;
            w_idx_nxt   = '0;
          end
        end else begin
          w_cnt_nxt = w_cnt_inc;
        end
      end
      RESYNC: begin
        if (w_level) begin
          w_cnt_nxt = '0;
        end else if (r_cnt >= CNT_RESET) begin
          w_state_nxt = IDLE;
        end else begin
          w_cnt_nxt = w_cnt_inc;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase

`ifdef UNIPOLAR_RZ_DECODER_FORWARD_EN
    if (w_frame_end_nxt || w_error_nxt) w_fwd_nxt = 1'b0;
`endif
  end

  assign data      = r_data;
  assign valid     = r_valid;
  assign frame_end = r_frame_end;
  assign error     = r_error;

`ifdef UNIPOLAR_RZ_DECODER_FORWARD_EN
  assign line_out = r_fwd & w_level;
`else
  assign line_out = 1'b0;
`endif

endmodule

// File: tb/tb_unipolar_rz_decoder.sv
// Self-checking bench for unipolar_rz_decoder: randomized pulse widths against a width-threshold model.
module tb_unipolar_rz_decoder;

  localparam int DW      = 24;
  localparam int THR     = (30 + 80) / 2;
  localparam int RST_LOW = 9000;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          line  = 1'b0;
  logic [DW-1:0] data;
  logic          valid;
  logic          frame_end;
  logic          error;
  logic          line_out;

  unipolar_rz_decoder dut (
    .clock     (clock),
    .reset     (reset),
    .line      (line),
    .data      (data),
    .valid     (valid),
    .frame_end (frame_end),
    .error     (error),
    .line_out  (line_out)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int n_vec = 0;
  int n_bad = 0;

  logic [DW-1:0] vq[$];
  int v_cyc = 0, fe_n = 0, fe_cyc = 0, er_n = 0, er_cyc = 0;
  int last_fall = 0;
  logic l1 = 1'b0, l2 = 1'b0;
  bit chk_zero = 1'b0, chk_mirror = 1'b0;
  int lo_bad = 0, lo_chk = 0;

  always @(negedge clock) begin
    if (valid === 1'b1) begin
      vq.push_back(data);
      v_cyc = cyc;
    end
    if (frame_end === 1'b1) begin
      fe_n++;
      fe_cyc = cyc;
    end
    if (error === 1'b1) begin
      er_n++;
      er_cyc = cyc;
    end
    if (chk_zero) begin
      lo_chk++;
      if (line_out !== 1'b0) lo_bad++;
    end
    if (chk_mirror) begin
      lo_chk++;
      if (line_out !== l2) lo_bad++;
    end
    l2 = l1;
    l1 = line;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic pulse(input int hi, input int lo);
    line = 1'b1;
    tick(hi);
    line = 1'b0;
    last_fall = cyc;
    tick(lo);
  endtask

  task automatic send_word(input logic [DW-1:0] w, input int h0, input int h1, input int per);
    for (int i = DW - 1; i >= 0; i--) begin
      int h;
      h = w[i] ? h1 : h0;
      pulse(h, per - h);
    end
  endtask

  task automatic send_rand_word(input logic [DW-1:0] w);
    for (int i = DW - 1; i >= 0; i--) begin
      int h;
      h = w[i] ? int'($urandom_range(110, 55)) : int'($urandom_range(54, 20));
      pulse(h, int'($urandom_range(60, 5)));
    end
  endtask

  task automatic send_rand_bits(input int n);
    for (int i = 0; i < n; i++) pulse(int'($urandom_range(100, 20)), int'($urandom_range(60, 5)));
  endtask

  task automatic do_reset;
    reset = 1'b1;
    tick(3);
    reset = 1'b0;
    tick(2);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    line  = 1'b0;
    tick(4);
    @(negedge clock);
    n_vec++; if (data !== '0)       begin n_bad++; $display("FAIL reset_data got=%h want=0", data); end
    n_vec++; if (valid !== 1'b0)    begin n_bad++; $display("FAIL reset_valid got=%b want=0", valid); end
    n_vec++; if (frame_end !== 1'b0) begin n_bad++; $display("FAIL reset_frame_end got=%b want=0", frame_end); end
    n_vec++; if (error !== 1'b0)    begin n_bad++; $display("FAIL reset_error got=%b want=0", error); end
    n_vec++; if (line_out !== 1'b0) begin n_bad++; $display("FAIL reset_line_out got=%b want=0", line_out); end
    reset = 1'b0;
    tick(2);
  endtask

  task automatic test_basic;
    int v0, f0, e0, lf;
    logic [DW-1:0] got;
    do_reset;
    v0 = vq.size(); f0 = fe_n; e0 = er_n;
    send_word(24'h00ff00, 30, 80, 120);
    lf = last_fall;
    tick(20);
    n_vec++; if (vq.size() - v0 !== 1) begin n_bad++; $display("FAIL basic_valid_count got=%0d want=1", vq.size() - v0); end
    got = (vq.size() > v0) ? vq[v0] : 'x;
    n_vec++; if (got !== 24'h00ff00) begin n_bad++; $display("FAIL basic_data got=%h want=00ff00", got); end
    n_vec++; if (v_cyc - lf !== 4) begin n_bad++; $display("FAIL basic_latency got=%0d want=4", v_cyc - lf); end
    tick(RST_LOW + 20);
    n_vec++; if (fe_n - f0 !== 1) begin n_bad++; $display("FAIL basic_frame_end got=%0d want=1", fe_n - f0); end
    n_vec++; if (er_n - e0 !== 0) begin n_bad++; $display("FAIL basic_error got=%0d want=0", er_n - e0); end
    n_vec++; if (vq.size() - v0 !== 1) begin n_bad++; $display("FAIL basic_valid_after got=%0d want=1", vq.size() - v0); end
  endtask

  task automatic test_threshold;
    int v0;
    logic [DW-1:0] w, exp_w, got;
    do_reset;
    v0 = vq.size();
    w = 24'($urandom);
    w[DW-1:DW-2] = 2'b10;
    exp_w = '0;
    for (int i = DW - 1; i >= 0; i--) begin
      int h;
      h = w[i] ? 55 : 54;
      exp_w = {exp_w[DW-2:0], (h >= THR)};
      pulse(h, 30);
    end
    tick(20);
    n_vec++; if (vq.size() - v0 !== 1) begin n_bad++; $display("FAIL thresh_valid_count got=%0d want=1", vq.size() - v0); end
    got = (vq.size() > v0) ? vq[v0] : 'x;
    n_vec++; if (got !== exp_w) begin n_bad++; $display("FAIL thresh_data got=%h want=%h", got, exp_w); end
  endtask

  task automatic test_long_high;
    int v0, f0, e0;
    logic [DW-1:0] got;
    do_reset;
    v0 = vq.size(); f0 = fe_n; e0 = er_n;
    send_rand_bits(5);
    pulse(130, RST_LOW + 30);
    n_vec++; if (er_n - e0 !== 1) begin n_bad++; $display("FAIL long_error got=%0d want=1", er_n - e0); end
    n_vec++; if (fe_n - f0 !== 0) begin n_bad++; $display("FAIL long_frame_end got=%0d want=0", fe_n - f0); end
    n_vec++; if (vq.size() - v0 !== 0) begin n_bad++; $display("FAIL long_valid got=%0d want=0", vq.size() - v0); end
    send_word(24'hA5A5A5, 30, 80, 120);
    tick(20);
    n_vec++; if (vq.size() - v0 !== 1) begin n_bad++; $display("FAIL long_next_count got=%0d want=1", vq.size() - v0); end
    got = (vq.size() > v0) ? vq[v0] : 'x;
    n_vec++; if (got !== 24'hA5A5A5) begin n_bad++; $display("FAIL long_next_data got=%h want=a5a5a5", got); end
  endtask

  task automatic test_partial;
    int v0, f0, e0;
    logic [DW-1:0] w, got;
    do_reset;
    v0 = vq.size(); f0 = fe_n; e0 = er_n;
    send_rand_bits(10);
    tick(RST_LOW + 30);
    n_vec++; if (fe_n - f0 !== 1) begin n_bad++; $display("FAIL partial_frame_end got=%0d want=1", fe_n - f0); end
    n_vec++; if (er_n - e0 !== 1) begin n_bad++; $display("FAIL partial_error got=%0d want=1", er_n - e0); end
    n_vec++; if (fe_cyc !== er_cyc) begin n_bad++; $display("FAIL partial_same_cycle got=%0d want=%0d", er_cyc, fe_cyc); end
    n_vec++; if (vq.size() - v0 !== 0) begin n_bad++; $display("FAIL partial_valid got=%0d want=0", vq.size() - v0); end
    w = 24'($urandom);
    send_rand_word(w);
    tick(20);
    got = (vq.size() > v0) ? vq[v0] : 'x;
    n_vec++; if (got !== w) begin n_bad++; $display("FAIL partial_next_data got=%h want=%h", got, w); end
  endtask

  task automatic test_reset_mid;
    int v0;
    logic [DW-1:0] got;
    v0 = vq.size();
    send_rand_bits(12);
    reset = 1'b1;
    tick(2);
    @(negedge clock);
    n_vec++; if (data !== '0) begin n_bad++; $display("FAIL midreset_data got=%h want=0", data); end
    n_vec++; if (valid !== 1'b0) begin n_bad++; $display("FAIL midreset_valid got=%b want=0", valid); end
    reset = 1'b0;
    tick(2);
    send_word(24'h123456, 30, 80, 120);
    tick(20);
    n_vec++; if (vq.size() - v0 !== 1) begin n_bad++; $display("FAIL midreset_count got=%0d want=1", vq.size() - v0); end
    got = (vq.size() > v0) ? vq[v0] : 'x;
    n_vec++; if (got !== 24'h123456) begin n_bad++; $display("FAIL midreset_word got=%h want=123456", got); end
  endtask

  task automatic test_back_to_back;
    int v0, n_exp;
    logic [DW-1:0] ws[3];
    logic [DW-1:0] got;
    do_reset;
    v0 = vq.size();
    for (int i = 0; i < 3; i++) begin
      ws[i] = 24'($urandom);
      send_rand_word(ws[i]);
    end
    tick(20);
`ifdef UNIPOLAR_RZ_DECODER_FORWARD_EN
    n_exp = 1;
`else
    n_exp = 3;
`endif
    n_vec++; if (vq.size() - v0 !== n_exp) begin n_bad++; $display("FAIL b2b_count got=%0d want=%0d", vq.size() - v0, n_exp); end
    for (int i = 0; i < n_exp; i++) begin
      got = (vq.size() > v0 + i) ? vq[v0 + i] : 'x;
      n_vec++; if (got !== ws[i]) begin n_bad++; $display("FAIL b2b_data%0d got=%h want=%h", i, got, ws[i]); end
    end
  endtask

`ifdef UNIPOLAR_RZ_DECODER_FORWARD_EN
  task automatic test_forward;
    int v0, f0, b0, c0;
    logic [DW-1:0] w, got;
    do_reset;
    v0 = vq.size(); f0 = fe_n; b0 = lo_bad; c0 = lo_chk;
    chk_zero = 1'b1;
    send_word(24'hFF0000, 30, 80, 120);
    chk_zero = 1'b0;
    chk_mirror = 1'b1;
    send_word(24'h0000FF, 30, 80, 120);
    tick(4);
    chk_mirror = 1'b0;
    tick(RST_LOW + 30);
    n_vec++; if (vq.size() - v0 !== 1) begin n_bad++; $display("FAIL fwd_valid_count got=%0d want=1", vq.size() - v0); end
    got = (vq.size() > v0) ? vq[v0] : 'x;
    n_vec++; if (got !== 24'hFF0000) begin n_bad++; $display("FAIL fwd_data got=%h want=ff0000", got); end
    n_vec++; if (fe_n - f0 !== 1) begin n_bad++; $display("FAIL fwd_frame_end got=%0d want=1", fe_n - f0); end
    n_vec++; if (lo_bad - b0 !== 0) begin n_bad++; $display("FAIL fwd_mirror bad_cycles=%0d want=0", lo_bad - b0); end
    chk_zero = 1'b1;
    w = 24'($urandom);
    send_rand_word(w);
    tick(20);
    chk_zero = 1'b0;
    n_vec++; if (lo_bad - b0 !== 0) begin n_bad++; $display("FAIL fwd_after_frame bad_cycles=%0d want=0", lo_bad - b0); end
    n_vec++; if (lo_chk - c0 < 1000) begin n_bad++; $display("FAIL fwd_checked cycles=%0d want>=1000", lo_chk - c0); end
    got = (vq.size() > v0 + 1) ? vq[v0 + 1] : 'x;
    n_vec++; if (got !== w) begin n_bad++; $display("FAIL fwd_new_frame_data got=%h want=%h", got, w); end
  endtask
`else
  task automatic test_line_out_off;
    n_vec++; if (lo_bad !== 0) begin n_bad++; $display("FAIL line_out_off bad_cycles=%0d want=0", lo_bad); end
    n_vec++; if (lo_chk < 1000) begin n_bad++; $display("FAIL line_out_checked cycles=%0d want>=1000", lo_chk); end
  endtask
`endif

  initial begin
`ifndef UNIPOLAR_RZ_DECODER_FORWARD_EN
    chk_zero = 1'b1;
`endif
    test_reset;
    test_basic;
    test_threshold;
    test_long_high;
    test_partial;
    test_reset_mid;
    test_back_to_back;
`ifdef UNIPOLAR_RZ_DECODER_FORWARD_EN
    test_forward;
`else
    test_line_out_off;
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
